tl_ul_sram_responder: RTL

TileLink-UL responder that terminates the `tl_m2s_t` / `tl_s2m_t` channel pair and services requests from a single-port synchronous SRAM. It is the responder end of the links our AHB-to-TL bridge drives: on-chip RAM and test memories attach here. It buffers responses so that D-channel back-pressure never drops data. With default depth it sustains one request per cycle.

---
 rtl/TileLinkUL_pkg.sv | 58 +++++
 rtl/tl_resp_fifo.sv | 53 +++++
 rtl/tl_ul_sram_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/TileLinkUL_pkg.sv
// TileLink-UL channel types shared by the bridge and its responders.
// Combinational only: widths, opcodes and the A/D channel structs.
// No flow control of its own; a_ready/d_ready are carried inside the structs.
package TileLinkUL_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_OFF = $clog2(TL_DBW);

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_m2s_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tl_s2m_t;

    // One queued D-channel response.
    typedef struct packed {
        tl_d_op_e            opcode;
        logic [TL_SZW-1:0]   size;
        logic [TL_AIW-1:0]   source;
        logic [TL_DW-1:0]    data;
        logic                error;
    } tl_d_rsp_t;

endpackage

// File: rtl/tl_resp_fifo.sv
// Synchronous FIFO of D-channel responses with an occupancy output.
// Latency: a pushed entry is visible at the head the following cycle.
// Backpressure: none internally; the writer must respect occ (no overflow guard).
module tl_resp_fifo
    import TileLinkUL_pkg::*;
#(
    parameter  int unsigned Depth = 3,
    localparam int unsigned OccW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_vld,
    input  tl_d_rsp_t       push_dat,
    input  logic            pop_vld,
    output logic            head_vld,
    output tl_d_rsp_t       head_dat,
    output logic [OccW-1:0] occ
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    tl_d_rsp_t       mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push_vld) wptr <= ptr_next(wptr);
            if (pop_vld)  rptr <= ptr_next(rptr);
            case ({push_vld, pop_vld})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) mem[wptr] <= push_dat;
    end

    assign head_vld = (occ != '0);
    assign head_dat = mem[rptr];

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder backed by a single-port SRAM; TL_SRAM_ERR_CHECK_EN enables request legality checks.
// Latency: request accepted in cycle t -> SRAM strobe in t, d_valid earliest in t+2.
// Backpressure: a_ready is credit-based (FIFO occupancy plus the in-flight s1 slot), never from d_ready.
module tl_ul_sram_responder
    import TileLinkUL_pkg::*;
#(
    parameter int MemAw     = 10,
    parameter int RespDepth = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tl_m2s_t           tl_i,
    output tl_s2m_t           tl_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MemAw-1:0]  mem_addr_o,
    output logic [TL_DW-1:0]  mem_wdata_o,
    output logic [TL_DBW-1:0] mem_wmask_o,
    input  logic [TL_DW-1:0]  mem_rdata_i
);

    localparam int unsigned OccW = $clog2(RespDepth + 1);

`ifdef TL_SRAM_ERR_CHECK_EN
    function automatic logic req_error(input tl_m2s_t a);
        logic [TL_DBW-1:0] lanes;
        logic [TL_OFF-1:0] lo;
        logic              err;
        lo  = a.a_address[TL_OFF-1:0];
        err = 1'b0;
        // Lanes covered by a naturally aligned access of 2^a_size bytes.
        for (int i = 0; i < TL_DBW; i++) begin
            lanes[i] = ((i >> a.a_size) == (int'(lo) >> a.a_size));
        end
        if (int'(a.a_size) > TL_OFF) err = 1'b1;
        if ((int'(lo) & ((1 << a.a_size) - 1)) != 0) err = 1'b1;
        if ((a.a_mask & ~lanes) != '0) err = 1'b1;
        if (a.a_opcode == PutFullData && a.a_mask != lanes) err = 1'b1;
        if (a.a_param != '0) err = 1'b1;
        if ((a.a_address >> (MemAw + TL_OFF)) != '0) err = 1'b1;
        if (!(a.a_opcode inside {PutFullData, PutPartialData, Get})) err = 1'b1;
        return err;
    endfunction
`endif

    logic              req_err;
    logic              a_ready;
    logic              accept;
    logic              d_valid;
    logic              pop;
    logic              fifo_vld;
    logic [OccW-1:0]   occ;
    tl_d_rsp_t         push_dat;
    tl_d_rsp_t         head_dat;

    logic              s1_valid;
    logic              s1_is_get;
    logic              s1_error;
    logic [TL_SZW-1:0] s1_size;
    logic [TL_AIW-1:0] s1_source;

`ifdef TL_SRAM_ERR_CHECK_EN
    assign req_err = req_error(tl_i);
`else
    assign req_err = 1'b0;
`endif

    // s1 holds a credit too, so the FIFO can always absorb the in-flight read.
    assign a_ready = rst_ni && ((32'(occ) + 32'(s1_valid)) < 32'(RespDepth));
    assign accept  = tl_i.a_valid && a_ready;

    assign mem_req_o   = accept && !req_err;
    assign mem_we_o    = mem_req_o && (tl_i.a_opcode != Get);
    assign mem_addr_o  = mem_req_o ? tl_i.a_address[MemAw+TL_OFF-1:TL_OFF] : '0;
    assign mem_wdata_o = mem_req_o ? tl_i.a_data : '0;
    assign mem_wmask_o = mem_req_o ? tl_i.a_mask : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_is_get <= 1'b0;
            s1_error  <= 1'b0;
            s1_size   <= '0;
            s1_source <= '0;
        end else begin
            s1_valid  <= accept;
            s1_is_get <= (tl_i.a_opcode == Get);
            s1_error  <= req_err;
            s1_size   <= tl_i.a_size;
            s1_source <= tl_i.a_source;
        end
    end

    always_comb begin
        push_dat        = '0;
        push_dat.opcode = s1_is_get ? AccessAckData : AccessAck;
        push_dat.size   = s1_size;
        push_dat.source = s1_source;
        push_dat.data   = (s1_is_get && !s1_error) ? mem_rdata_i : '0;
        push_dat.error  = s1_error;
    end

    tl_resp_fifo #(
        .Depth (RespDepth)
    ) u_resp_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (s1_valid),
        .push_dat (push_dat),
        .pop_vld  (pop),
        .head_vld (fifo_vld),
        .head_dat (head_dat),
        .occ      (occ)
    );

    assign d_valid = rst_ni && fifo_vld;
    assign pop     = d_valid && tl_i.d_ready;

    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        if (d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = head_dat.opcode;
            tl_o.d_size   = head_dat.size;
            tl_o.d_source = head_dat.source;
            tl_o.d_data   = head_dat.data;
            tl_o.d_error  = head_dat.error;
        end
    end

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address};

endmodule
